pattern_serializer: RTL and testbench
=====================================

# pattern_serializer

Parametrised pattern serializer. A DEPTH-entry table holds WIDTH-bit patterns. On request, the block latches the selected pattern and shifts it out one bit per clock, either once or continuously, with a selectable bit order and an output-enable gate. It sits between the lab-board control inputs (pattern select, enable) and a single-bit serial output line, and replaces the fixed 8-bit counter/decoder/mux serializer.

## Interface
Parameters:
- WIDTH, 8, bits per pattern (≥2)
- DEPTH, 8, pattern table entries (≥2)
- SEL_W, $clog2(DEPTH), select width (derived, not overridden)
- IDX_W, $clog2(WIDTH), bit-index width (derived)

Ports:
- clock  in  1  single clock, rising edge
- clear  in  1  synchronous active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- stop  in  1  end continuous mode at the next frame boundary
- mode  in  1  0 = one-shot, 1 = continuous; latched at start
- msb_first  in  1  0 = bit 0 first, 1 = bit WIDTH-1 first; latched at start and at each reload
- sel  in  SEL_W  pattern table index
- en  in  1  output gate
- out  out  1  serial bit
- valid  out  1  out carries a pattern bit
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse with the last bit of every frame
- bit_idx  out  IDX_W  position of the current bit within the frame (0..WIDTH-1)

## Operation
- FSM states: IDLE and SHIFT.
- Transition IDLE→SHIFT:
  - start=1 at an edge while in IDLE.
  - Latches table[sel], mode and msb_first, and sets bit_idx=0.
- Output mapping:
  - out = shift_reg[bit_idx] when msb_first=0.
  - out = shift_reg[WIDTH-1-bit_idx] when msb_first=1.
  - out is gated by en.
- In SHIFT, bit_idx increments each edge.
- When bit_idx=WIDTH-1:
  - done=1 for that cycle.
  - mode=0, or mode=1 with the stop flag set: the next edge goes to IDLE.
  - mode=1 with the stop flag clear: the next edge reloads table[sel] (current sel), re-latches msb_first and wraps bit_idx to 0 with no gap cycle.
- Stop flag:
  - Set by stop=1 at any SHIFT edge.
  - Cleared on entry to IDLE.
  - Ignored in one-shot mode.
- sel changes during a frame never affect the latched frame.
- start while busy=1 is ignored.
- Enable gating:
  - en=0 forces out=0 and valid=0.
  - Sequencing (bit_idx, done, busy) continues unaffected.
- Combinational outputs: busy=(state==SHIFT); valid=busy&en.
- Table initial contents:
  - Entry k = thermometer code (2^(k+1))−1, truncated to WIDTH bits.
  - Entries k ≥ WIDTH are all ones.
  - Example (WIDTH=8): 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3F, 0x7F, 0xFF.
- clear: at the next edge, state=IDLE, bit_idx=0, shift_reg=0, stop flag=0. This applies mid-frame, with no done pulse. clear has priority over start.

## Timing
- Reset values: out=0, valid=0, busy=0, done=0, bit_idx=0.
- Latency: start sampled at edge t, so the first bit is present from edge t until edge t+1.
- A one-shot frame occupies exactly WIDTH cycles, with done in the cycle of the last bit (t+WIDTH−1 to t+WIDTH). busy=0 from edge t+WIDTH.
- Back-to-back one-shot: start held high gives one idle cycle between frames.
- Continuous frames are contiguous: done pulses every WIDTH cycles.
- stop is honoured at the first frame boundary at or after its sampling edge.

## Configuration
- PATTERN_SER_WRITE_EN defined:
  - Adds ports wr_en (in 1), wr_addr (in SEL_W) and wr_data (in WIDTH).
  - With wr_en=1, table[wr_addr] is updated at the edge.
  - A write and a load of the same entry at the same edge: the load takes the old data.
  - Writes never alter an already latched frame.
  - clear does not restore the table.
- PATTERN_SER_WRITE_EN undefined: the table is a constant ROM holding the initial contents, and the write ports are absent.

## Structure
- Package pattern_ser_pkg holds:
  - state enum (IDLE, SHIFT)
  - the thermometer-init function
  - default WIDTH/DEPTH constants
- Sub-module pattern_table: table storage, combinational read port, optional write port under the macro.

## Test plan
WIDTH=8, DEPTH=8 throughout.
- clear, then sel=3, msb_first=0, mode=0, start pulse → out 1,1,1,1,0,0,0,0 over 8 cycles; done in cycle 8; busy=0 afterwards.
- sel=3, msb_first=1, one-shot → out 0,0,0,0,1,1,1,1.
- mode=1, sel=0, start; set sel=7 during bit 3 → first frame 1,0,0,0,0,0,0,0 then 1×8 with no gap cycle. Then stop pulse at bit 2 of the second frame → frame completes, busy=0 one cycle after done.
- en=0 during bits 2–5 of a sel=7 frame → out=0 and valid=0 for those cycles; bit_idx still advances; done still pulses at bit 7.
- clear at bit_idx=4 → next cycle busy=0, out=0, bit_idx=0, no done. A start asserted at bit 2 of a separate frame is ignored.
- With PATTERN_SER_WRITE_EN: write 0xA5 to address 2, then start sel=2, LSB-first → 1,0,1,0,0,1,0,1. A write to address 2 mid-frame does not change the current frame.

Source files
------------

// File: rtl/pattern_ser_pkg.sv
// Shared definitions for the pattern serializer: FSM state type, default
// geometry and the thermometer-code generator used to seed the pattern table.
// Optional table write port is enabled with the PATTERN_SER_WRITE_EN macro.
package pattern_ser_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Widest pattern the thermometer generator can describe.
  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Entry k is (2^(k+1))-1 truncated to width bits; entries k >= width come out all ones.
  function automatic logic [MAX_WIDTH-1:0] therm_init(input int k, input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_WIDTH; b++) begin
      r[b] = (b <= k) && (b < width);
    end
    return r;
  endfunction

endpackage

// File: rtl/pattern_table.sv
// Pattern table storage with a combinational read port.
// With PATTERN_SER_WRITE_EN defined the table is writable at the clock edge
// (power-up contents are the thermometer codes and are not restored by clear);
// otherwise it is a constant ROM of thermometer codes.
module pattern_table import pattern_ser_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SEL_W = $clog2(DEPTH)
) (
`ifdef PATTERN_SER_WRITE_EN
  input  logic             clock,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
`endif
  input  logic [SEL_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Storage covers the full select range so any select value reads a defined
  // entry; slots beyond DEPTH are filler and read back as all ones.
  localparam int SLOTS = 1 << SEL_W;

  function automatic logic [SLOTS-1:0][WIDTH-1:0] init_table();
    logic [SLOTS-1:0][WIDTH-1:0] t;
    logic [MAX_WIDTH-1:0]        full;
    t = '1;
    for (int k = 0; k < DEPTH; k++) begin
      full = therm_init(k, WIDTH);
      t[k] = full[WIDTH-1:0];
    end
    return t;
  endfunction

`ifdef PATTERN_SER_WRITE_EN
  logic [SLOTS-1:0][WIDTH-1:0] mem = init_table();

  // Table write; a read of the same entry in this cycle still sees the old word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
`else
  localparam logic [SLOTS-1:0][WIDTH-1:0] ROM = init_table();

  assign rd_data = ROM[rd_addr];
`endif

endmodule

// File: rtl/pattern_serializer.sv
// Parametrised pattern serializer: latches a table pattern on start and shifts
// it out one bit per clock, one-shot or continuous, LSB- or MSB-first, with an
// output-enable gate. Defining PATTERN_SER_WRITE_EN adds a table write port.
module pattern_serializer import pattern_ser_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SEL_W = $clog2(DEPTH),
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             msb_first,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
`ifdef PATTERN_SER_WRITE_EN
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
`endif
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx
);

  ser_state_e       state, state_n;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] rd_data;
  logic             mode_q, mode_n;
  logic             msb_q;
  logic             stop_flag, stop_n;
  logic [IDX_W-1:0] bit_idx_n;
  logic [IDX_W-1:0] out_pos;
  logic             load;
  logic             last;

  pattern_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_table (
`ifdef PATTERN_SER_WRITE_EN
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .rd_addr (sel),
    .rd_data (rd_data)
  );

  assign last = (bit_idx == IDX_W'(WIDTH - 1));

  // Next-state logic: start a frame from IDLE, then step bits and decide at the
  // frame boundary whether to stop or reload the next frame with no gap.
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    mode_n    = mode_q;
    stop_n    = stop_flag;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = SHIFT;
          mode_n    = mode;
          bit_idx_n = '0;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (stop) begin
          stop_n = 1'b1;
        end
        if (last) begin
          bit_idx_n = '0;
          if (!mode_q || stop_flag || stop) begin
            state_n = IDLE;
            stop_n  = 1'b0;
          end else begin
            load = 1'b1;
          end
        end else begin
          bit_idx_n = bit_idx + IDX_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; clear aborts any frame without a done pulse.
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shift_reg <= '0;
      stop_flag <= 1'b0;
      mode_q    <= 1'b0;
      msb_q     <= 1'b0;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_idx_n;
      stop_flag <= stop_n;
      mode_q    <= mode_n;
      if (load) begin
        shift_reg <= rd_data;
        msb_q     <= msb_first;
      end
    end
  end

  // Output decode: pick the current bit in the latched order and gate by enable.
  always_comb begin
    busy    = (state == SHIFT);
    valid   = busy & en;
    done    = busy & last;
    out_pos = msb_q ? (IDX_W'(WIDTH - 1) - bit_idx) : bit_idx;
    out     = valid & shift_reg[out_pos];
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer (WIDTH=8, DEPTH=8). A frame-level
// reference model (table contents plus per-cycle input plans) predicts every
// output bit. Table-write checks are included when PATTERN_SER_WRITE_EN is defined.
module tb_pattern_serializer;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int SW = 3;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          clear, start, stop, mode, msb_first, en;
  logic [SW-1:0] sel;
  logic          out, valid, busy, done;
  logic [IW-1:0] bit_idx;
`ifdef PATTERN_SER_WRITE_EN
  logic          wr_en;
  logic [SW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference table contents and per-cycle input plan for the next frame.
  logic [W-1:0]  tbl [D];
  bit            enPlan [W];
  bit            stopPlan [W];
  bit            startPlan [W];
  bit            msbPlan [W];
  logic [SW-1:0] selPlan [W];
`ifdef PATTERN_SER_WRITE_EN
  bit            wrPlan [W];
  logic [SW-1:0] wrAddrPlan [W];
  logic [W-1:0]  wrDataPlan [W];
`endif
  logic [W-1:0]  nextPat;
  bit            nextMsb;

  pattern_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .msb_first (msb_first),
    .sel       (sel),
    .en        (en),
`ifdef PATTERN_SER_WRITE_EN
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .out       (out),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .bit_idx   (bit_idx)
  );

  // Free-running 10-time-unit clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit m, input bit msb, input logic [SW-1:0] sl);
    start     = s;
    mode      = m;
    msb_first = msb;
    sel       = sl;
    stop      = 1'b0;
    en        = 1'b1;
  endtask

  task automatic resetPlan(input logic [SW-1:0] sl, input bit msb);
    for (int j = 0; j < W; j++) begin
      enPlan[j]    = 1'b1;
      stopPlan[j]  = 1'b0;
      startPlan[j] = 1'b0;
      msbPlan[j]   = msb;
      selPlan[j]   = sl;
`ifdef PATTERN_SER_WRITE_EN
      wrPlan[j]     = 1'b0;
      wrAddrPlan[j] = '0;
      wrDataPlan[j] = '0;
`endif
    end
  endtask

  task automatic randomPlan();
    for (int j = 0; j < W; j++) begin
      enPlan[j]    = ($urandom_range(0, 3) != 0);
      stopPlan[j]  = 1'b0;
      startPlan[j] = $urandom_range(0, 1) == 1;
      msbPlan[j]   = $urandom_range(0, 1) == 1;
      selPlan[j]   = SW'($urandom_range(0, D - 1));
`ifdef PATTERN_SER_WRITE_EN
      wrPlan[j]     = ($urandom_range(0, 3) == 0);
      wrAddrPlan[j] = SW'($urandom_range(0, D - 1));
      wrDataPlan[j] = W'($urandom);
`endif
    end
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #2;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " valid"}, 32'(valid), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " bit_idx"}, 32'(bit_idx), 32'd0);
  endtask

  // Checks nBits cycles of a frame carrying pat in the given order, driving the
  // planned inputs each cycle; records what the boundary edge will reload.
  task automatic playFrame(input string tag, input logic [W-1:0] pat, input bit msb, input int nBits);
    logic expBit;
    for (int j = 0; j < nBits; j++) begin
      @(posedge clock);
      #1;
      en        = enPlan[j];
      stop      = stopPlan[j];
      start     = startPlan[j];
      sel       = selPlan[j];
      msb_first = msbPlan[j];
`ifdef PATTERN_SER_WRITE_EN
      wr_en     = wrPlan[j];
      wr_addr   = wrAddrPlan[j];
      wr_data   = wrDataPlan[j];
`endif
      #1;
      expBit = enPlan[j] & pat[msb ? (W - 1 - j) : j];
      checkOutput($sformatf("%s b%0d out", tag, j), 32'(out), 32'(expBit));
      checkOutput($sformatf("%s b%0d valid", tag, j), 32'(valid), 32'(enPlan[j]));
      checkOutput($sformatf("%s b%0d busy", tag, j), 32'(busy), 32'd1);
      checkOutput($sformatf("%s b%0d bit_idx", tag, j), 32'(bit_idx), 32'(j));
      checkOutput($sformatf("%s b%0d done", tag, j), 32'(done), 32'(j == W - 1));
      if (j == W - 1) begin
        nextPat = tbl[selPlan[j]];
        nextMsb = msbPlan[j];
      end
`ifdef PATTERN_SER_WRITE_EN
      if (wrPlan[j]) tbl[wrAddrPlan[j]] = wrDataPlan[j];
`endif
    end
  endtask

  task automatic endFrame(input string tag, input bit holdStart);
    @(posedge clock);
    #1;
    start = holdStart;
    stop  = 1'b0;
    en    = 1'b1;
`ifdef PATTERN_SER_WRITE_EN
    wr_en = 1'b0;
`endif
    #1;
    checkIdle(tag);
  endtask

  initial begin
    logic [SW-1:0] s;
    bit            m;
    logic [W-1:0]  pat;
    int            nFrames;

    for (int k = 0; k < D; k++) tbl[k] = (k + 1 >= W) ? '1 : W'((1 << (k + 1)) - 1);

    clear = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
`ifdef PATTERN_SER_WRITE_EN
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`endif
    waitCycle();
    waitCycle();
    checkOutput("reset out", 32'(out), 32'd0);
    checkIdle("reset");
    clear = 1'b0;
    waitCycle();
    checkIdle("post-reset");

    $display("[TB] one-shot LSB-first and MSB-first, sel=3");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd3);
    resetPlan(3'd3, 1'b0);
    playFrame("lsb3", tbl[3], 1'b0, W);
    endFrame("lsb3 end", 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd3);
    resetPlan(3'd3, 1'b1);
    playFrame("msb3", tbl[3], 1'b1, W);
    endFrame("msb3 end", 1'b0);

    $display("[TB] continuous with sel change and stop");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0);
    resetPlan(3'd0, 1'b0);
    for (int j = 3; j < W; j++) selPlan[j] = 3'd7;
    playFrame("cont1", tbl[0], 1'b0, W);
    pat = nextPat;
    m   = nextMsb;
    resetPlan(3'd7, 1'b0);
    stopPlan[2] = 1'b1;
    playFrame("cont2", pat, m, W);
    endFrame("cont end", 1'b0);

    $display("[TB] enable gating on sel=7");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd7);
    resetPlan(3'd7, 1'b0);
    for (int j = 2; j <= 5; j++) enPlan[j] = 1'b0;
    playFrame("gate", tbl[7], 1'b0, W);
    endFrame("gate end", 1'b0);

    $display("[TB] clear mid-frame, then start while busy");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd5);
    resetPlan(3'd5, 1'b0);
    playFrame("abort", tbl[5], 1'b0, 5);
    clear = 1'b1;
    waitCycle();
    clear = 1'b0;
    checkOutput("abort out", 32'(out), 32'd0);
    checkIdle("abort");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd1);
    resetPlan(3'd1, 1'b0);
    startPlan[2] = 1'b1;
    selPlan[2]   = 3'd6;
    playFrame("ignstart", tbl[1], 1'b0, W);
    endFrame("ignstart end", 1'b0);
    waitCycle();
    checkIdle("ignstart idle");

    $display("[TB] back-to-back one-shot with start held");
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2);
    resetPlan(3'd2, 1'b1);
    for (int j = 0; j < W; j++) startPlan[j] = 1'b1;
    playFrame("b2b1", tbl[2], 1'b1, W);
    endFrame("b2b gap", 1'b1);
    resetPlan(sel, msb_first);
    playFrame("b2b2", tbl[sel], msb_first, W);
    endFrame("b2b2 end", 1'b0);

    $display("[TB] random one-shot frames");
    repeat (8) begin
      s = SW'($urandom_range(0, D - 1));
      m = $urandom_range(0, 1) == 1;
      applyStimulus(1'b1, 1'b0, m, s);
      pat = tbl[s];
      randomPlan();
      playFrame("rnd1", pat, m, W);
      endFrame("rnd1 end", 1'b0);
    end

    $display("[TB] random continuous runs");
    repeat (4) begin
      s = SW'($urandom_range(0, D - 1));
      m = $urandom_range(0, 1) == 1;
      applyStimulus(1'b1, 1'b1, m, s);
      pat = tbl[s];
      nFrames = $urandom_range(2, 4);
      for (int f = 0; f < nFrames; f++) begin
        randomPlan();
        if (f == nFrames - 1) stopPlan[$urandom_range(0, W - 1)] = 1'b1;
        playFrame($sformatf("rndc f%0d", f), pat, m, W);
        pat = nextPat;
        m   = nextMsb;
      end
      endFrame("rndc end", 1'b0);
    end

`ifdef PATTERN_SER_WRITE_EN
    $display("[TB] table writes");
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hA5;
    waitCycle();
    wr_en = 1'b0;
    tbl[2] = 8'hA5;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd2);
    resetPlan(3'd2, 1'b0);
    wrPlan[3] = 1'b1; wrAddrPlan[3] = 3'd2; wrDataPlan[3] = 8'h3C;
    playFrame("wrA5", tbl[2], 1'b0, W);
    endFrame("wrA5 end", 1'b0);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h5A;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd4);
    pat = tbl[4];
    tbl[4] = 8'h5A;
    resetPlan(3'd4, 1'b0);
    playFrame("wrsame", pat, 1'b0, W);
    endFrame("wrsame end", 1'b0);
    clear = 1'b1;
    waitCycle();
    clear = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd4);
    resetPlan(3'd4, 1'b1);
    playFrame("wrnew4", tbl[4], 1'b1, W);
    endFrame("wrnew4 end", 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd2);
    resetPlan(3'd2, 1'b0);
    playFrame("wrkeep2", tbl[2], 1'b0, W);
    endFrame("wrkeep2 end", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
